// File: rtl/exerion_rom_loader.sv
// Exerion ROM loader: splits the index-0 ioctl download into six ROM regions,
// tracks length/overflow/checksum and holds the core in reset until a good image is in.
module exerion_rom_loader #(
    parameter logic [24:0] SUB_BASE  = 25'h06000,
    parameter logic [24:0] FG_BASE   = 25'h08000,
    parameter logic [24:0] SPR_BASE  = 25'h0A000,
    parameter logic [24:0] BG_BASE   = 25'h0E000,
    parameter logic [24:0] PROM_BASE = 25'h16000,
    parameter logic [24:0] TOTAL_LEN = 25'h16320,
    parameter int          RST_HOLD  = 16
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic [5:0]  rom_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_rst_n,
    output logic        rom_ready,
    output logic        load_error,
    output logic [7:0]  checksum
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_READY, S_ERROR
    } state_t;

    state_t          r_state;
    logic            r_dn_dl;
    logic [24:0]     r_byte_cnt;
    logic            r_overflow;
    logic [HW-1:0]   r_hold_cnt;

    logic            w_rise;
    logic            w_fall;
    logic            w_acc;
    logic            w_in_range;
    logic [5:0]      w_sel;
    logic [15:0]     w_base;

    assign w_rise     = dn_download & ~r_dn_dl;
    assign w_fall     = ~dn_download & r_dn_dl;
    // The byte arriving with the falling edge of dn_download still belongs to the load.
    assign w_acc      = dn_wr & (dn_download | w_fall) & (w_rise | (r_state == S_LOAD));
    assign w_in_range = (dn_addr < TOTAL_LEN);

    always_comb begin
        w_sel  = 6'b000001;
        w_base = 16'h0000;
        if (dn_addr >= PROM_BASE) begin
            w_sel  = 6'b100000;
            w_base = PROM_BASE[15:0];
        end else if (dn_addr >= BG_BASE) begin
            w_sel  = 6'b010000;
            w_base = BG_BASE[15:0];
        end else if (dn_addr >= SPR_BASE) begin
            w_sel  = 6'b001000;
            w_base = SPR_BASE[15:0];
        end else if (dn_addr >= FG_BASE) begin
            w_sel  = 6'b000100;
            w_base = FG_BASE[15:0];
        end else if (dn_addr >= SUB_BASE) begin
            w_sel  = 6'b000010;
            w_base = SUB_BASE[15:0];
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= S_IDLE;
            r_dn_dl    <= 1'b0;
            r_byte_cnt <= '0;
            r_overflow <= 1'b0;
            r_hold_cnt <= '0;
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            core_rst_n <= 1'b0;
            rom_ready  <= 1'b0;
            load_error <= 1'b0;
            checksum   <= '0;
        end else begin
            r_dn_dl <= dn_download;
            rom_we  <= '0;

            // Offset only needs the low 16 bits: the borrow never reaches them.
            if (w_acc && w_in_range) begin
                rom_we   <= w_sel;
                rom_addr <= dn_addr[15:0] - w_base;
                rom_data <= dn_data;
            end

            if (w_rise) begin
                r_state    <= S_LOAD;
                r_byte_cnt <= w_acc ? 25'd1 : 25'd0;
                checksum   <= w_acc ? dn_data : 8'h00;
                r_overflow <= w_acc & ~w_in_range;
                r_hold_cnt <= '0;
                core_rst_n <= 1'b0;
                rom_ready  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                if (w_acc) begin
                    if (r_byte_cnt != '1)
                        r_byte_cnt <= r_byte_cnt + 25'd1;
                    checksum <= checksum + dn_data;
                    if (!w_in_range)
                        r_overflow <= 1'b1;
                end

                case (r_state)
                    S_LOAD: begin
                        if (w_fall)
                            r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (r_byte_cnt == TOTAL_LEN && !r_overflow) begin
                            r_state    <= S_HOLD;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state    <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == HW'(RST_HOLD - 1)) begin
                            r_state    <= S_READY;
                            rom_ready  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exerion_rom_loader.sv
// Bench for exerion_rom_loader: region map scaled down by 0x20 so whole images stream quickly;
// a behavioural model predicts every output each cycle, literals pin the model.
module tb_exerion_rom_loader;

    localparam logic [24:0] T_SUB  = 25'h300;
    localparam logic [24:0] T_FG   = 25'h400;
    localparam logic [24:0] T_SPR  = 25'h500;
    localparam logic [24:0] T_BG   = 25'h700;
    localparam logic [24:0] T_PROM = 25'hB00;
    localparam logic [24:0] T_TOT  = 25'hB19;
    localparam int          T_HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        RESET_n = 1'b0;
    logic        dn_download = 1'b0;
    logic        dn_wr = 1'b0;
    logic [24:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic [5:0]  rom_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_rst_n, rom_ready, load_error;
    logic [7:0]  checksum;

    exerion_rom_loader #(
        .SUB_BASE(T_SUB), .FG_BASE(T_FG), .SPR_BASE(T_SPR), .BG_BASE(T_BG),
        .PROM_BASE(T_PROM), .TOTAL_LEN(T_TOT), .RST_HOLD(T_HOLD)
    ) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .dn_download(dn_download), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_data(rom_data), .core_rst_n(core_rst_n), .rom_ready(rom_ready),
        .load_error(load_error), .checksum(checksum)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_prev, m_sess, m_done, m_good, m_ovf, chk_ad;
    int          m_cnt, m_age;
    logic [7:0]  m_sum;
    logic [5:0]  exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    bit          exp_rst, exp_rdy, exp_err;
    int          scnt [6];
    logic [24:0] aq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int region(input logic [24:0] a);
        logic [24:0] b [6];
        int r;
        b = '{25'h0, T_SUB, T_FG, T_SPR, T_BG, T_PROM};
        r = 0;
        for (int i = 0; i < 6; i++) if (a >= b[i]) r = i;
        return r;
    endfunction

    function automatic logic [24:0] base_of(input int r);
        logic [24:0] b [6];
        b = '{25'h0, T_SUB, T_FG, T_SPR, T_BG, T_PROM};
        return b[r];
    endfunction

    task automatic model_reset();
        m_prev = 0; m_sess = 0; m_done = 0; m_good = 0; m_ovf = 0;
        m_cnt = 0; m_age = 0; m_sum = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0; chk_ad = 1;
        exp_rst = 0; exp_rdy = 0; exp_err = 0;
    endtask

    // Applies the rules to the inputs seen at the edge just taken.
    task automatic model_step();
        bit rise, fall, acc;
        int r;
        rise = dn_download && !m_prev;
        fall = !dn_download && m_prev;
        m_prev = dn_download;
        acc = dn_wr && (dn_download || fall) && (m_sess || rise);
        if (rise) begin
            m_sess = 1; m_done = 0; m_cnt = 0; m_sum = 0; m_ovf = 0;
        end
        exp_we = 0; chk_ad = 0;
        if (acc) begin
            m_cnt++;
            m_sum = m_sum + dn_data;
            if (dn_addr < T_TOT) begin
                r = region(dn_addr);
                exp_we = 6'(1 << r);
                exp_addr = 16'(dn_addr - base_of(r));
                exp_data = dn_data;
                chk_ad = 1;
            end else begin
                m_ovf = 1;
            end
        end
        if (fall && m_sess) begin
            m_sess = 0; m_done = 1; m_age = 0;
            m_good = (m_cnt == int'(T_TOT)) && !m_ovf;
        end
        if (m_done) m_age++;
        exp_rst = m_done && m_good && (m_age >= T_HOLD + 2);
        exp_rdy = exp_rst;
        exp_err = m_done && !m_good && (m_age >= 2);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk_sys);
            chk("rom_we", rom_we, exp_we);
            if (chk_ad) begin
                chk("rom_addr", rom_addr, exp_addr);
                chk("rom_data", rom_data, exp_data);
            end
            chk("core_rst_n", core_rst_n, exp_rst);
            chk("rom_ready", rom_ready, exp_rdy);
            chk("load_error", load_error, exp_err);
            chk("checksum", checksum, m_sum);
            for (int b = 0; b < 6; b++) if (rom_we[b]) scnt[b]++;
        end
    end

    task automatic cyc(input logic dl, input logic wr, input logic [24:0] a, input logic [7:0] d);
        dn_download = dl; dn_wr = wr; dn_addr = a; dn_data = d;
        @(posedge clk_sys);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 25'($urandom), 8'($urandom));
    endtask

    task automatic fill(input int n);
        aq.delete();
        for (int i = 0; i < n; i++) aq.push_back(25'(i));
    endtask

    task automatic shuffle_q();
        int j;
        logic [24:0] t;
        for (int i = aq.size() - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = aq[i]; aq[i] = aq[j]; aq[j] = t;
        end
    endtask

    task automatic clr_cnt();
        for (int b = 0; b < 6; b++) scnt[b] = 0;
    endtask

    // Streams aq; returns just after the edge that ends the dn_fall cycle.
    task automatic run_session(input bit rnd_data, input bit fall_wr, input bit gaps);
        logic [7:0] d;
        for (int i = 0; i < aq.size(); i++) begin
            d = rnd_data ? 8'($urandom) : aq[i][7:0];
            if (fall_wr && i == aq.size() - 1) cyc(0, 1, aq[i], d);
            else cyc(1, 1, aq[i], d);
            if (gaps && i < aq.size() - 2 && $urandom_range(0, 3) == 0)
                cyc(1, 0, 25'($urandom), 8'($urandom));
        end
        if (!fall_wr) cyc(0, 0, 25'h0, 8'h0);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, ".rom_we"}, rom_we, 0);
        chk({tag, ".rom_addr"}, rom_addr, 0);
        chk({tag, ".rom_data"}, rom_data, 0);
        chk({tag, ".core_rst_n"}, core_rst_n, 0);
        chk({tag, ".rom_ready"}, rom_ready, 0);
        chk({tag, ".load_error"}, load_error, 0);
        chk({tag, ".checksum"}, checksum, 0);
    endtask

    initial begin
        int k, tot;
        logic [7:0] sum_keep;
        logic [24:0] first;

        // reset state
        RESET_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        outs_zero("reset");
        RESET_n = 1'b1;
        idle(3);

        // full in-order image, data = addr[7:0]
        clr_cnt();
        fill(int'(T_TOT));
        run_session(0, 0, 1);
        k = 1;
        while (core_rst_n !== 1'b1 && k < 100) begin
            cyc(0, 0, 25'h0, 8'h0);
            k++;
        end
        chk("rst_release_latency", k, T_HOLD + 2);
        chk("full.rom_ready", rom_ready, 1);
        chk("full.checksum", checksum, 8'hAC);
        chk("full.cnt_main", scnt[0], 32'h300);
        chk("full.cnt_sub", scnt[1], 32'h100);
        chk("full.cnt_fg", scnt[2], 32'h100);
        chk("full.cnt_spr", scnt[3], 32'h200);
        chk("full.cnt_bg", scnt[4], 32'h400);
        chk("full.cnt_prom", scnt[5], 32'h19);
        idle(3);

        // reload while READY: shuffled, random data, last byte on the dn_fall cycle
        fill(int'(T_TOT));
        shuffle_q();
        first = aq.pop_front();
        cyc(1, 1, first, 8'($urandom));
        chk("reload.rom_ready_drop", rom_ready, 0);
        chk("reload.core_rst_n_drop", core_rst_n, 0);
        run_session(1, 1, 1);
        cyc(0, 0, 25'h0, 8'h0);
        sum_keep = checksum;
        cyc(0, 1, 25'h10, 8'h55);
        chk("late_wr.rom_we", rom_we, 0);
        chk("late_wr.checksum", checksum, sum_keep);
        idle(20);
        chk("reload.rom_ready", rom_ready, 1);

        // short image
        clr_cnt();
        fill(int'(T_PROM));
        run_session(1, 0, 1);
        idle(5);
        chk("short.load_error", load_error, 1);
        chk("short.core_rst_n", core_rst_n, 0);
        chk("short.cnt_prom", scnt[5], 0);

        // overflow: full image plus one byte past the end
        clr_cnt();
        fill(int'(T_TOT));
        aq.push_back(T_TOT);
        run_session(1, 0, 0);
        idle(20);
        tot = 0;
        for (int b = 0; b < 6; b++) tot += scnt[b];
        chk("ovf.strobes", tot, T_TOT);
        chk("ovf.load_error", load_error, 1);
        chk("ovf.rom_ready", rom_ready, 0);

        // duplicate address inflates the count
        fill(int'(T_TOT));
        shuffle_q();
        aq.push_back(aq[5]);
        run_session(1, 0, 1);
        idle(20);
        chk("dup.load_error", load_error, 1);

        // region boundaries
        cyc(1, 1, 25'h2FF, 8'h11);
        chk("bnd0.we", rom_we, 6'b000001);  chk("bnd0.addr", rom_addr, 16'h2FF);
        cyc(1, 1, 25'h300, 8'h22);
        chk("bnd1.we", rom_we, 6'b000010);  chk("bnd1.addr", rom_addr, 16'h000);
        cyc(1, 1, 25'hAFF, 8'h33);
        chk("bnd2.we", rom_we, 6'b010000);  chk("bnd2.addr", rom_addr, 16'h3FF);
        cyc(1, 1, 25'hB00, 8'h44);
        chk("bnd3.we", rom_we, 6'b100000);  chk("bnd3.addr", rom_addr, 16'h000);
        chk("bnd3.data", rom_data, 8'h44);
        cyc(1, 1, 25'h705, 8'h55);
        chk("bnd4.we", rom_we, 6'b010000);  chk("bnd4.addr", rom_addr, 16'h005);
        cyc(0, 0, 25'h0, 8'h0);
        idle(3);
        chk("bnd.checksum", checksum, 8'hFF);
        chk("bnd.load_error", load_error, 1);

        // reset mid-load
        fill(100);
        shuffle_q();
        for (int i = 0; i < aq.size(); i++) cyc(1, 1, aq[i], 8'($urandom));
        RESET_n = 1'b0;
        dn_download = 1'b0; dn_wr = 1'b0;
        model_reset();
        #1;
        outs_zero("midreset");
        repeat (2) @(posedge clk_sys);
        #1;
        RESET_n = 1'b1;
        idle(30);
        chk("midreset.core_rst_n", core_rst_n, 0);

        // good load after the abort
        fill(int'(T_TOT));
        shuffle_q();
        run_session(1, 0, 1);
        idle(20);
        chk("final.rom_ready", rom_ready, 1);
        chk("final.core_rst_n", core_rst_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
